// File: rtl/mux_rr_reg.sv
// ============================================================================
// Module   : mux_rr_reg
// Purpose  : N-to-1 channel mux feeding a 1-deep registered output slice,
//            with either fixed select (MODE 0) or round-robin grant (MODE 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_rr_reg #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 8,
  parameter int MODE     = 0,
  localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic [CHANNELS*WIDTH-1:0] Hyrja,
  input  logic [CHANNELS-1:0]       HyrjaValid,
  output logic [CHANNELS-1:0]       HyrjaReady,
  input  logic [SELW-1:0]           s,
  output logic [WIDTH-1:0]          Dalja,
  output logic                      DaljaValid,
  input  logic                      DaljaReady,
  output logic [SELW-1:0]           Kanali
);

  logic [SELW-1:0]  w_gnt;
  logic             w_gnt_vld;
  logic [WIDTH-1:0] w_data;
  logic             w_accept;
  logic             w_load;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_kanali;

  assign w_accept = !r_valid || DaljaReady;
  assign w_load   = w_gnt_vld && w_accept;

  generate
    if (MODE == 0) begin : g_fixed
      // Out-of-range selects match no channel and therefore grant nothing.
      always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          if (s == SELW'(k)) begin
            w_gnt     = s;
            w_gnt_vld = HyrjaValid[k];
          end
        end
      end
    end else begin : g_rr
      logic [SELW-1:0] r_ptr;
      logic            w_unused_s;

      assign w_unused_s = ^s;

      // Lowest valid channel at or above ptr wins; otherwise wrap to lowest valid.
      always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
          if (HyrjaValid[k]) begin
            w_gnt     = SELW'(k);
            w_gnt_vld = 1'b1;
          end
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
          if (HyrjaValid[k] && (SELW'(k) >= r_ptr)) begin
            w_gnt = SELW'(k);
          end
        end
      end

      always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
          r_ptr <= '0;
        end else if (w_load) begin
          r_ptr <= (int'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_gnt == SELW'(k)) begin
        w_data = Hyrja[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    HyrjaReady = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_gnt_vld && (w_gnt == SELW'(k))) begin
        HyrjaReady[k] = w_accept && ResetN;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_kanali <= '0;
    end else if (w_load) begin
      r_data   <= w_data;
      r_kanali <= w_gnt;
      r_valid  <= 1'b1;
    end else if (DaljaReady) begin
      r_valid  <= 1'b0;
    end
  end

  assign Dalja      = r_data;
  assign DaljaValid = r_valid;
  assign Kanali     = r_kanali;

endmodule

`default_nettype wire

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter WIDTH, default 24, data word width in bits.
REQ-002 Parameter CHANNELS, default 8, number of input channels; legal range 2..32.
REQ-003 Parameter MODE, default 0; 0 = fixed select by s, 1 = round-robin arbitration.
REQ-004 Derived SELW = max(1, ceil(log2(CHANNELS))).
REQ-005 Clock  input  1  sole clock; all state updates on rising edge.
REQ-006 ResetN  input  1  asynchronous, active-low reset.
REQ-007 Hyrja  input  CHANNELS*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 HyrjaValid  input  CHANNELS  per-channel data-valid.
REQ-009 HyrjaReady  output  CHANNELS  per-channel accept, combinational; at most one bit high.
REQ-010 s  input  SELW  channel select, used in MODE 0 only, ignored in MODE 1.
REQ-011 Dalja  output  WIDTH  registered output word.
REQ-012 DaljaValid  output  1  Dalja holds an untaken word.
REQ-013 DaljaReady  input  1  downstream accepts Dalja this cycle.
REQ-014 Kanali  output  SELW  index of the channel Dalja came from, registered with Dalja.

Function
REQ-015 Block SHALL hold exactly one output word (1-deep register slice).
REQ-016 accept = !DaljaValid || DaljaReady, combinational.
REQ-017 MODE 0: grant = s when s < CHANNELS and HyrjaValid[s]=1; otherwise no grant.
REQ-018 MODE 1: grant = first channel with HyrjaValid=1 searching ptr, ptr+1, ... wrapping modulo CHANNELS; no grant if none valid.
REQ-019 HyrjaReady[grant] = accept; all other HyrjaReady bits 0; all 0 when no grant.
REQ-020 Transfer in: when grant exists and accept=1, on the edge Dalja<=Hyrja[grant], Kanali<=grant, DaljaValid<=1.
REQ-021 Transfer out: DaljaValid && DaljaReady; if no transfer in same cycle, DaljaValid<=0, Dalja and Kanali hold.
REQ-022 Simultaneous out and in: new word loaded, DaljaValid stays 1; zero bubble, full throughput of one word per cycle.
REQ-023 Latency: input word appears on Dalja one cycle after its transfer-in edge.
REQ-024 While DaljaValid=1 and DaljaReady=0, Dalja, Kanali and DaljaValid SHALL be stable and all HyrjaReady=0.
REQ-025 MODE 1 pointer: on each transfer in, ptr<=(grant+1) mod CHANNELS, correct for non-power-of-two CHANNELS (CHANNELS-1 wraps to 0); ptr holds otherwise.
REQ-026 MODE 0: changes to s while stalled SHALL not alter held Dalja or Kanali.
REQ-027 HyrjaValid deasserted without handshake SHALL have no effect on state.
REQ-028 No combinational path from DaljaReady to Dalja, DaljaValid or Kanali.

Reset
REQ-029 ResetN low SHALL immediately force Dalja=0, DaljaValid=0, Kanali=0, ptr=0, regardless of Clock.
REQ-030 During reset all HyrjaReady SHALL be 0; word held at reset assertion is discarded.
REQ-031 First transfer-in possible on first rising edge after ResetN deasserts.

Verification
REQ-032 MODE 0, CHANNELS=8: s=5, HyrjaValid=0x20, Hyrja ch5=0xABCDEF, DaljaReady=1 -> HyrjaReady=0x20, next cycle Dalja=0xABCDEF, Kanali=5, DaljaValid=1.
REQ-033 MODE 1, CHANNELS=8, all HyrjaValid=0xFF, DaljaReady=1 for 10 cycles -> Kanali sequence 0,1,...,7,0,1.
REQ-034 MODE 1, CHANNELS=5, HyrjaValid=0b10001 continuous -> Kanali alternates 0,4,0,4; ptr wraps 4->0 correctly.
REQ-035 Stall: DaljaValid=1 with Dalja=0x000123, DaljaReady=0 for 3 cycles while inputs and s change -> Dalja=0x000123 and Kanali unchanged, HyrjaReady=0; DaljaReady=1 then loads next word same edge.
REQ-036 ResetN pulsed low mid-stall between edges -> Dalja=0, DaljaValid=0, Kanali=0 before next edge; MODE 1 resumes granting from channel 0.
REQ-037 MODE 0, CHANNELS=6, s=7 with HyrjaValid=0x3F -> HyrjaReady=0, DaljaValid falls after drain, no load.
